ring_ro_seq: RTL and testbench
==============================

Name: ring_ro_seq

Overview:
- Parametrised successor of the ring-buffer readout address controller for the digitizer.
- On a read request, snapshots the write pointer, offset and word count.
- Walks backwards-offset addresses forward through the ring with modulo wrap, one address per accepted ready/valid beat, and sweeps NCH channels per sample.
- Sits between the SPI readout engine (consumer) and the per-channel sample RAMs (address sink).

Parameters:
ADDR_W, 12, ring address width; ring depth is 2**ADDR_W
NCH, 4, channels read per sample slot (1..16)
CH_W, 2, channel index width, equal to max(1, clog2(NCH))

Ports:
sysclk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
rd_request  in  1  level; a rising edge starts a readout, a low level aborts one
ain  in  ADDR_W  current ring write pointer
offset_i  in  ADDR_W  pre-trigger depth in samples
howmany_i  in  ADDR_W  samples to read; 0 means none
addr_ready  in  1  consumer (SPI) accepts the current beat
addr_valid  out  1  address/channel beat is valid
address  out  ADDR_W  ring address; 0 when not valid
chan_o  out  CH_W  channel index of the beat
ro_done_n  out  1  high while samples remain
howmany_left  out  ADDR_W  samples still to issue, including the current one
busy  out  1  sequencer not idle
done_p  out  1  one-cycle pulse when the last beat is accepted

Behaviour:
- Reset values: state IDLE; addr_valid=0; address=0; chan_o=0; ro_done_n=0; howmany_left=all-ones; busy=0; done_p=0.
- Input registration: rd_request is registered once; a start is detected on registered 0->1.
- IDLE:
  - On start with howmany_i!=0: capture start pointer = ain - offset_i - 1, modulo 2**ADDR_W with natural wrap and no saturation.
  - Also capture cnt = howmany_i and ch = 0.
  - Go to RUN, with busy=1 in the following cycle.
  - On start with howmany_i==0: pulse done_p the next cycle, stay IDLE, addr_valid never asserted.
- RUN:
  - addr_valid=1; address = pointer; chan_o = ch; howmany_left = cnt; ro_done_n = (cnt!=0).
  - Beat accepted when addr_valid && addr_ready. Hold everything stable while addr_ready=0.
  - On an accepted beat with ch<NCH-1: ch increments, pointer and cnt unchanged.
  - On an accepted beat with ch==NCH-1: ch=0, pointer+1 (wraps 2**ADDR_W-1 -> 0), cnt-1.
  - On an accepted beat with ch==NCH-1 and cnt==1: go to DONE.
- DONE (one cycle):
  - done_p=1, addr_valid=0, ro_done_n=0, howmany_left=0.
  - Next state is WAIT_LOW.
- WAIT_LOW: busy=1; return to IDLE once registered rd_request==0. This prevents re-triggering on a held request.
- Abort: registered rd_request==0 during RUN -> IDLE next cycle.
  - addr_valid drops; no done_p.
  - howmany_left = all-ones; ro_done_n=0.
- Simultaneous events:
  - A beat accept in the same cycle as an abort is not counted.
  - A start is only recognised in IDLE.
- Inputs ain, offset_i and howmany_i are sampled only at start; later changes are ignored.
- Latency: rd_request edge -> first addr_valid is 2 cycles (input register plus load).
- Throughput: one beat per cycle while addr_ready=1.
- Total beats per readout: howmany_i*NCH.
- Asynchronous reset mid-readout: all outputs return to reset values immediately; no done_p.

Decomposition:
- Package ring_ro_pkg holds:
  - the state enum (IDLE, RUN, DONE, WAIT_LOW)
  - localparam RING_DEPTH = 2**ADDR_W
  - the ALL_ONES constant
- One sub-module is natural: ring_ptr_wrap, a modulo-depth pointer with load and increment, reused by the write-side controller.
- Channel counter and FSM stay inline.

Test Plan:
- Basic readout: NCH=1, ain=100, offset_i=10, howmany_i=3, addr_ready=1.
  - Addresses must be 89, 90, 91 on consecutive cycles.
  - done_p must fire 1 cycle after the last beat.
  - howmany_left must read 3, 2, 1.
- Start-pointer wrap: ain=5, offset_i=10, howmany_i=4.
  - Start pointer is 4090; addresses must be 4090, 4091, 4092, 4093.
- End-of-ring wrap: ain=0, offset_i=0, howmany_i=2.
  - Addresses must be 4095, then 0.
- Backpressure with channel sweep: NCH=4, howmany_i=2, addr_ready toggles 1,0,1,0...
  - Each (address, chan) beat must be held while addr_ready=0.
  - Beat sequence must be (A,0)(A,1)(A,2)(A,3)(A+1,0)…(A+1,3), exactly 8 accepts.
- Zero count and re-trigger:
  - howmany_i=0: must produce a single done_p and no addr_valid.
  - Holding rd_request high after done: must not restart until it drops and rises again.
- Abort and reset:
  - Dropping rd_request after 2 beats: addr_valid=0 next cycle, no done_p, howmany_left=0xFFF.
  - Asserting rst_n=0 mid-RUN: immediate reset values, checked asynchronously between clock edges.

Source files
------------

// File: rtl/ring_ro_pkg.sv
// Shared types and constants for the ring-buffer readout sequencer.
//   ro_state_e  : sequencer state encoding
//   DEF_ADDR_W  : default ring address width
//   RING_DEPTH  : ring depth for the default width
//   ALL_ONES    : idle value of the remaining-sample count at default width
package ring_ro_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned RING_DEPTH = 2 ** DEF_ADDR_W;
  localparam logic [DEF_ADDR_W-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DONE     = 2'd2,
    WAIT_LOW = 2'd3
  } ro_state_e;

endpackage

// File: rtl/ring_ro_seq_if.sv
// Address/channel beat bus between the readout sequencer and its consumer.
//   addr_valid : beat is valid (sequencer -> consumer)
//   addr_ready : consumer accepts the beat (consumer -> sequencer)
//   address    : ring address of the beat
//   chan_o     : channel index of the beat
interface ring_ro_seq_if
  import ring_ro_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CH_W   = 2
);

  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] address;
  logic [CH_W-1:0]   chan_o;

  modport master (
    output addr_valid,
    output address,
    output chan_o,
    input  addr_ready
  );

  modport slave (
    input  addr_valid,
    input  address,
    input  chan_o,
    output addr_ready
  );

endinterface

// File: rtl/ring_ptr_wrap.sv
// Modulo-depth ring pointer with load and increment.
// The ring depth is 2**ADDR_W, so the natural binary wrap of the
// register gives the modulo behaviour without a compare.
//   sysclk   : clock
//   rst_n    : asynchronous active-low reset
//   load     : load load_val (takes priority over inc)
//   load_val : value to load
//   inc      : advance the pointer by one, wrapping to 0
//   ptr      : current pointer
module ring_ptr_wrap #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  // Pointer register: load wins over increment.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/ring_ro_seq.sv
// Ring-buffer readout address sequencer.
// On a rising edge of rd_request, snapshots the write pointer, pre-trigger
// offset and sample count, then issues one (address, channel) beat per
// accepted ready/valid handshake, sweeping NCH channels per ring slot and
// advancing the ring pointer with modulo wrap after the last channel.
//   sysclk       : clock
//   rst_n        : asynchronous active-low reset
//   rd_request   : level request; rising edge starts, low level aborts
//   ain          : current ring write pointer
//   offset_i     : pre-trigger depth in samples
//   howmany_i    : samples to read (0 = none)
//   ro_bus       : beat bus (addr_valid/addr_ready/address/chan_o)
//   ro_done_n    : high while samples remain
//   howmany_left : samples still to issue, including the current one
//   busy         : sequencer not idle
//   done_p       : one-cycle pulse after the last beat is accepted
module ring_ro_seq
  import ring_ro_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NCH    = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              rd_request,
  input  logic [ADDR_W-1:0] ain,
  input  logic [ADDR_W-1:0] offset_i,
  input  logic [ADDR_W-1:0] howmany_i,
  ring_ro_seq_if.master     ro_bus,
  output logic              ro_done_n,
  output logic [ADDR_W-1:0] howmany_left,
  output logic              busy,
  output logic              done_p
);

  localparam logic [CH_W-1:0]   CH_LAST = CH_W'(NCH - 1);
  localparam logic [ADDR_W-1:0] HM_IDLE = '1;

  ro_state_e         state;
  logic              req_q;
  logic              req_qq;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] ptr;
  logic              addr_valid_q;
  logic [ADDR_W-1:0] address_q;
  logic [CH_W-1:0]   chan_q;

  logic              start_c;
  logic              load_c;
  logic              accept_c;
  logic              last_ch_c;
  logic              inc_c;
  logic [ADDR_W-1:0] start_ptr_c;

  assign ro_bus.addr_valid = addr_valid_q;
  assign ro_bus.address    = address_q;
  assign ro_bus.chan_o     = chan_q;

  // Start on a registered 0->1; only meaningful while IDLE.
  assign start_c     = req_q & ~req_qq;
  // First sample sits one slot before the pre-trigger window; natural wrap.
  assign start_ptr_c = ain - offset_i - ADDR_W'(1);
  assign load_c      = (state == IDLE) && start_c && (howmany_i != '0);
  // An abort (req_q low) in the same cycle swallows the accept.
  assign accept_c    = (state == RUN) && req_q && addr_valid_q && ro_bus.addr_ready;
  assign last_ch_c   = (chan_q == CH_LAST);
  assign inc_c       = accept_c && last_ch_c;

  ring_ptr_wrap #(
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .load     (load_c),
    .load_val (start_ptr_c),
    .inc      (inc_c),
    .ptr      (ptr)
  );

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_q        <= 1'b0;
      req_qq       <= 1'b0;
      cnt          <= '0;
      addr_valid_q <= 1'b0;
      address_q    <= '0;
      chan_q       <= '0;
      ro_done_n    <= 1'b0;
      howmany_left <= HM_IDLE;
      busy         <= 1'b0;
      done_p       <= 1'b0;
    end else begin
      req_q  <= rd_request;
      req_qq <= req_q;
      done_p <= 1'b0;

      case (state)
        IDLE: begin
          if (load_c) begin
            state        <= RUN;
            cnt          <= howmany_i;
            addr_valid_q <= 1'b1;
            address_q    <= start_ptr_c;
            chan_q       <= '0;
            ro_done_n    <= 1'b1;
            howmany_left <= howmany_i;
            busy         <= 1'b1;
          end else if (start_c) begin
            // Zero-length readout: report completion without any beat.
            done_p <= 1'b1;
          end
        end

        RUN: begin
          if (!req_q) begin
            state        <= IDLE;
            addr_valid_q <= 1'b0;
            address_q    <= '0;
            chan_q       <= '0;
            ro_done_n    <= 1'b0;
            howmany_left <= HM_IDLE;
            busy         <= 1'b0;
          end else if (accept_c) begin
            if (!last_ch_c) begin
              chan_q <= chan_q + CH_W'(1);
            end else begin
              chan_q <= '0;
              if (cnt == ADDR_W'(1)) begin
                state        <= DONE;
                cnt          <= '0;
                addr_valid_q <= 1'b0;
                address_q    <= '0;
                ro_done_n    <= 1'b0;
                howmany_left <= '0;
                done_p       <= 1'b1;
              end else begin
                cnt          <= cnt - ADDR_W'(1);
                howmany_left <= cnt - ADDR_W'(1);
                address_q    <= ptr + ADDR_W'(1);
              end
            end
          end
        end

        DONE: begin
          state <= WAIT_LOW;
        end

        WAIT_LOW: begin
          // Hold off until the request drops so a held level cannot re-trigger.
          if (!req_q) begin
            state        <= IDLE;
            busy         <= 1'b0;
            howmany_left <= HM_IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_ro_seq.sv
// Directed bench for ring_ro_seq: one instance with NCH=1, one with NCH=4,
// sharing clock, reset and request inputs; each test observes one of them.
module tb_ring_ro_seq;

  localparam int unsigned AW = 12;

  logic          sysclk;
  logic          rst_n;
  logic          rd_request;
  logic [AW-1:0] ain;
  logic [AW-1:0] offset_i;
  logic [AW-1:0] howmany_i;
  logic          ready1;
  logic          ready4;

  logic          ro_done_n1, ro_done_n4;
  logic [AW-1:0] hl1, hl4;
  logic          busy1, busy4;
  logic          done_p1, done_p4;

  int n_tests = 0;
  int n_fail  = 0;

  ring_ro_seq_if #(.ADDR_W(AW), .CH_W(1)) bus1 ();
  ring_ro_seq_if #(.ADDR_W(AW), .CH_W(2)) bus4 ();

  assign bus1.addr_ready = ready1;
  assign bus4.addr_ready = ready4;

  ring_ro_seq #(.ADDR_W(AW), .NCH(1), .CH_W(1)) dut1 (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .rd_request   (rd_request),
    .ain          (ain),
    .offset_i     (offset_i),
    .howmany_i    (howmany_i),
    .ro_bus       (bus1.master),
    .ro_done_n    (ro_done_n1),
    .howmany_left (hl1),
    .busy         (busy1),
    .done_p       (done_p1)
  );

  ring_ro_seq #(.ADDR_W(AW), .NCH(4), .CH_W(2)) dut4 (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .rd_request   (rd_request),
    .ain          (ain),
    .offset_i     (offset_i),
    .howmany_i    (howmany_i),
    .ro_bus       (bus4.master),
    .ro_done_n    (ro_done_n4),
    .howmany_left (hl4),
    .busy         (busy4),
    .done_p       (done_p4)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Drop the request and let both instances settle back to IDLE.
  task automatic release_req();
    rd_request = 1'b0;
    repeat (3) tick();
  endtask

  task automatic start_req(input logic [AW-1:0] a, input logic [AW-1:0] o,
                           input logic [AW-1:0] h);
    ain        = a;
    offset_i   = o;
    howmany_i  = h;
    rd_request = 1'b1;
    tick();
    tick();
  endtask

  // NCH=1 readout with all-ready consumer; checks each address and count.
  task automatic run1(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] o,
                      input int n, input logic [AW-1:0] first);
    logic [AW-1:0] exp_addr;
    ready1 = 1'b1;
    start_req(a, o, AW'(n));
    exp_addr = first;
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, 32'(bus1.addr_valid), 32'd1);
      check({tag, "_addr"}, 32'(bus1.address), 32'(exp_addr));
      check({tag, "_left"}, 32'(hl1), 32'(n - i));
      exp_addr = exp_addr + AW'(1);
      tick();
    end
    check({tag, "_done_p"}, 32'(done_p1), 32'd1);
    check({tag, "_valid_end"}, 32'(bus1.addr_valid), 32'd0);
    release_req();
    check({tag, "_idle"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    logic        rdy;
    int          k;
    logic [AW-1:0] a_base;

    rst_n      = 1'b0;
    rd_request = 1'b0;
    ain        = '0;
    offset_i   = '0;
    howmany_i  = '0;
    ready1     = 1'b1;
    ready4     = 1'b1;
    repeat (2) @(posedge sysclk);
    #1;
    check("rst_valid", 32'(bus4.addr_valid), 32'd0);
    check("rst_addr", 32'(bus4.address), 32'd0);
    check("rst_chan", 32'(bus4.chan_o), 32'd0);
    check("rst_ro_done_n", 32'(ro_done_n4), 32'd0);
    check("rst_left", 32'(hl4), 32'hFFF);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done_p", 32'(done_p4), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic, start-pointer wrap and end-of-ring wrap on the NCH=1 instance.
    run1("basic", 12'd100, 12'd10, 3, 12'd89);
    run1("swrap", 12'd5, 12'd10, 4, 12'd4090);
    run1("ewrap", 12'd0, 12'd0, 2, 12'd4095);

    // Backpressure with channel sweep on the NCH=4 instance.
    a_base = 12'd16;
    ready4 = 1'b1;
    start_req(12'd20, 12'd3, 12'd2);
    check("bp_ro_done_n", 32'(ro_done_n4), 32'd1);
    check("bp_busy", 32'(busy4), 32'd1);
    k   = 0;
    rdy = 1'b1;
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      ready4 = rdy;
      check("bp_valid", 32'(bus4.addr_valid), 32'd1);
      check("bp_addr", 32'(bus4.address), 32'(a_base + AW'(k / 4)));
      check("bp_chan", 32'(bus4.chan_o), 32'(k % 4));
      check("bp_left", 32'(hl4), (k < 4) ? 32'd2 : 32'd1);
      if (rdy) k++;
      rdy = ~rdy;
      tick();
    end
    check("bp_accepts", 32'(k), 32'd8);
    check("bp_done_p", 32'(done_p4), 32'd1);
    check("bp_valid_end", 32'(bus4.addr_valid), 32'd0);
    check("bp_left_end", 32'(hl4), 32'd0);
    ready4 = 1'b1;
    release_req();
    check("bp_idle", 32'(busy4), 32'd0);

    // Zero count: a single done_p, never a valid beat, no restart while held.
    start_req(12'd50, 12'd0, 12'd0);
    check("zero_done_p", 32'(done_p4), 32'd1);
    check("zero_valid", 32'(bus4.addr_valid), 32'd0);
    check("zero_busy", 32'(busy4), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("zero_hold_done_p", 32'(done_p4), 32'd0);
      check("zero_hold_valid", 32'(bus4.addr_valid), 32'd0);
    end
    release_req();

    // Re-trigger guard on the NCH=1 instance with a held request.
    ready1 = 1'b1;
    start_req(12'd50, 12'd0, 12'd1);
    check("rt_addr", 32'(bus1.address), 32'd49);
    tick();
    check("rt_done_p", 32'(done_p1), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rt_hold_valid", 32'(bus1.addr_valid), 32'd0);
      check("rt_hold_busy", 32'(busy1), 32'd1);
    end
    release_req();
    check("rt_idle", 32'(busy1), 32'd0);
    start_req(12'd60, 12'd0, 12'd1);
    check("rt_again_valid", 32'(bus1.addr_valid), 32'd1);
    check("rt_again_addr", 32'(bus1.address), 32'd59);
    release_req();

    // Abort after two accepted beats; the accept during the abort is dropped.
    ready4 = 1'b1;
    start_req(12'd100, 12'd0, 12'd5);
    tick();
    tick();
    check("ab_chan2", 32'(bus4.chan_o), 32'd2);
    rd_request = 1'b0;
    ready4     = 1'b0;
    tick();
    check("ab_pre_valid", 32'(bus4.addr_valid), 32'd1);
    check("ab_pre_chan", 32'(bus4.chan_o), 32'd2);
    ready4 = 1'b1;
    tick();
    check("ab_valid", 32'(bus4.addr_valid), 32'd0);
    check("ab_addr", 32'(bus4.address), 32'd0);
    check("ab_chan", 32'(bus4.chan_o), 32'd0);
    check("ab_left", 32'(hl4), 32'hFFF);
    check("ab_ro_done_n", 32'(ro_done_n4), 32'd0);
    check("ab_done_p", 32'(done_p4), 32'd0);
    check("ab_busy", 32'(busy4), 32'd0);
    tick();
    check("ab_done_p2", 32'(done_p4), 32'd0);
    release_req();

    // Asynchronous reset in the middle of a readout.
    ready4 = 1'b1;
    start_req(12'd10, 12'd0, 12'd3);
    tick();
    check("ar_pre_busy", 32'(busy4), 32'd1);
    check("ar_pre_chan", 32'(bus4.chan_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus4.addr_valid), 32'd0);
    check("ar_addr", 32'(bus4.address), 32'd0);
    check("ar_chan", 32'(bus4.chan_o), 32'd0);
    check("ar_left", 32'(hl4), 32'hFFF);
    check("ar_ro_done_n", 32'(ro_done_n4), 32'd0);
    check("ar_busy", 32'(busy4), 32'd0);
    check("ar_done_p", 32'(done_p4), 32'd0);
    rd_request = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    check("ar_after_valid", 32'(bus4.addr_valid), 32'd0);
    check("ar_after_done_p", 32'(done_p4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
